stream_to_axi_collector: RTL and testbench



---
 rtl/stream_to_axi_collector_if.sv | 28 ++
 rtl/stream_to_axi_collector.sv | 142 ++++++++++++++
 tb/tb_stream_to_axi_collector.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_to_axi_collector_if.sv
// Lane-side and AXI-stream-side signals of the probe result collector.
interface stream_to_axi_collector_if #(
  parameter int SN_WIDTH = 32
);
  logic [7:0]          in_valid;
  logic [7:0]          in_ready;
  logic [7:0][63:0]    in_data;
  logic [7:0]          in_hit;
  logic [7:0][63:0]    in_serialnum;
  logic [7:0]          in_last;
  logic [511:0]        out_data;
  logic [7:0]          out_keep;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic [SN_WIDTH-1:0] curr_sn;
  logic                err_sn;

  modport slave (
    input  in_valid, in_data, in_hit, in_serialnum, in_last, out_ready,
    output in_ready, out_data, out_keep, out_valid, out_last, curr_sn, err_sn
  );

  modport master (
    output in_valid, in_data, in_hit, in_serialnum, in_last, out_ready,
    input  in_ready, out_data, out_keep, out_valid, out_last, curr_sn, err_sn
  );
endinterface

// File: rtl/stream_to_axi_collector.sv
// Reassembles per-lane 64-bit probe results by serial number into 512-bit beats,
// publishing the next awaited serial (curr_sn) back to the splitter.
module stream_to_axi_collector #(
  parameter bit EMIT_EMPTY = 1'b0,
  parameter int SN_WIDTH   = 32
) (
  input logic                      clk,
  input logic                      reset,
  stream_to_axi_collector_if.slave bus
);
  localparam int LANES = 8;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FLUSH   = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                  state_q;
  logic [LANES-1:0][63:0]  slot_data_q;
  logic [LANES-1:0]        slot_hit_q;
  logic [LANES-1:0]        slot_full_q;
  logic [511:0]            out_data_q;
  logic [7:0]              out_keep_q;
  logic                    out_valid_q;
  logic                    out_last_q;
  logic [SN_WIDTH-1:0]     curr_sn_q;
  logic                    err_sn_q;

  logic [SN_WIDTH-1:0]     sn_diff [LANES];
  logic [LANES-1:0]        lane_ok;
  logic [LANES-1:0]        sn_match;
  logic [LANES-1:0]        drop;
  logic [LANES-1:0]        ready;
  logic [LANES-1:0]        take;
  logic                    collect;
  logic                    out_free;
  logic                    pack_fire;
  logic                    bad_fire;
  logic                    flush_go;
  logic                    partial_last;

  // Serial "behind" is judged by the sign of the modular difference, so wrap needs no care.
  always_comb begin
    collect  = (state_q == COLLECT);
    sn_diff  = '{default: '0};
    lane_ok  = '0;
    sn_match = '0;
    drop     = '0;
    ready    = '0;
    take     = '0;
    for (int i = 0; i < LANES; i++) begin
      sn_diff[i]  = bus.in_serialnum[i][SN_WIDTH-1:0] - curr_sn_q;
      lane_ok[i]  = (bus.in_serialnum[i][63:32] == 32'(i));
      sn_match[i] = (sn_diff[i] == '0);
      drop[i]     = !lane_ok[i] || sn_diff[i][SN_WIDTH-1];
      ready[i]    = collect && !reset && (drop[i] || (sn_match[i] && !slot_full_q[i]));
      take[i]     = bus.in_valid[i] && ready[i] && !drop[i];
    end
    out_free     = !out_valid_q || bus.out_ready;
    pack_fire    = collect && (&slot_full_q) && out_free;
    bad_fire     = |(bus.in_valid & ready & drop);
    flush_go     = collect && (&bus.in_last) && (slot_full_q == '0);
    partial_last = collect && (&bus.in_last) && (|slot_full_q) && !(&(slot_full_q | take));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= COLLECT;
      slot_data_q <= '0;
      slot_hit_q  <= '0;
      slot_full_q <= '0;
      out_data_q  <= '0;
      out_keep_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      curr_sn_q   <= '0;
      err_sn_q    <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (take[i]) begin
          slot_data_q[i] <= bus.in_hit[i] ? bus.in_data[i] : 64'd0;
          slot_hit_q[i]  <= bus.in_hit[i];
          slot_full_q[i] <= 1'b1;
        end
      end
      if (bad_fire || partial_last) begin
        err_sn_q <= 1'b1;
      end
      case (state_q)
        COLLECT: begin
          if (pack_fire) begin
            out_data_q  <= slot_data_q;
            out_keep_q  <= slot_hit_q;
            out_last_q  <= 1'b0;
            out_valid_q <= (|slot_hit_q) || EMIT_EMPTY;
            slot_full_q <= '0;
            slot_hit_q  <= '0;
            curr_sn_q   <= curr_sn_q + 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
          if (flush_go) begin
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (out_free) begin
            out_data_q  <= '0;
            out_keep_q  <= 8'h00;
            out_last_q  <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          out_valid_q <= 1'b0;
        end
        default: begin
          state_q <= COLLECT;
        end
      endcase
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_keep  = out_keep_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.curr_sn   = curr_sn_q;
  assign bus.err_sn    = err_sn_q;

endmodule

// File: tb/tb_stream_to_axi_collector.sv
// Directed bench: two collectors in lockstep (EMIT_EMPTY=0/SN_WIDTH=32 and
// EMIT_EMPTY=1/SN_WIDTH=4) driven by per-lane entry queues.
module tb_stream_to_axi_collector;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0]       in_valid, in_hit, in_last;
  logic [7:0][63:0] in_data, in_serialnum;
  logic             out_ready;

  stream_to_axi_collector_if #(.SN_WIDTH(32)) ifa ();
  stream_to_axi_collector_if #(.SN_WIDTH(4))  ifb ();

  assign ifa.in_valid = in_valid;  assign ifb.in_valid = in_valid;
  assign ifa.in_data = in_data;    assign ifb.in_data = in_data;
  assign ifa.in_hit = in_hit;      assign ifb.in_hit = in_hit;
  assign ifa.in_serialnum = in_serialnum;  assign ifb.in_serialnum = in_serialnum;
  assign ifa.in_last = in_last;    assign ifb.in_last = in_last;
  assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready;

  stream_to_axi_collector #(.EMIT_EMPTY(1'b0), .SN_WIDTH(32)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  stream_to_axi_collector #(.EMIT_EMPTY(1'b1), .SN_WIDTH(4))  dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  typedef struct { int t; logic [31:0] sn; logic [31:0] lane; logic hit; logic [63:0] data; } ent_t;
  typedef struct { logic [511:0] data; logic [7:0] keep; logic last; int cyc; } beat_t;
  typedef struct { logic [31:0] sn; logic [7:0] hits; logic [7:0] exp_keep; bit emit_a; bit emit_b; logic [63:0] exp_lane1; } vec_t;

  ent_t  lq [8][$];
  beat_t ba[$], bb[$];
  vec_t  tbl [6];
  int    cyc = 0, checks = 0, errors = 0;
  int    stall_lo = 0, stall_hi = 0, fire5_cyc = -1;
  logic [7:0]   last_mask = 8'h00;
  logic [511:0] snap;

  task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] exp_beat(logic [31:0] sn, logic [7:0] hits);
    logic [511:0] d;
    d = '0;
    for (int i = 0; i < 8; i++) if (hits[i]) d[i*64 +: 64] = (64'(sn) << 8) | 64'(i);
    return d;
  endfunction

  task automatic drive();
    for (int i = 0; i < 8; i++) begin
      if (lq[i].size() != 0 && lq[i][0].t <= cyc) begin
        in_valid[i] = 1'b1;
        in_serialnum[i] = {lq[i][0].lane, lq[i][0].sn};
        in_hit[i] = lq[i][0].hit;
        in_data[i] = lq[i][0].data;
      end else begin
        in_valid[i] = 1'b0;
        in_serialnum[i] = {32'(i), 32'd0};
        in_hit[i] = 1'b0;
        in_data[i] = 64'd0;
      end
    end
    out_ready = !(cyc >= stall_lo && cyc < stall_hi);
    in_last = last_mask;
  endtask

  // Sample handshakes on the falling edge, advance queues just after the rising edge.
  task automatic step();
    logic [7:0] fire;
    ent_t e;
    @(negedge clk);
    fire = in_valid & ifa.in_ready;
    if (fire[5] && fire5_cyc < 0) fire5_cyc = cyc;
    if (ifa.out_valid && out_ready) ba.push_back('{ifa.out_data, ifa.out_keep, ifa.out_last, cyc});
    if (ifb.out_valid && out_ready) bb.push_back('{ifb.out_data, ifb.out_keep, ifb.out_last, cyc});
    @(posedge clk); #1;
    cyc++;
    for (int i = 0; i < 8; i++) if (fire[i]) e = lq[i].pop_front();
    drive();
  endtask

  task automatic do_reset();
    for (int i = 0; i < 8; i++) lq[i].delete();
    stall_lo = 0; stall_hi = 0; last_mask = 8'h00; fire5_cyc = -1;
    reset = 1'b1;
    drive();
    step(); step();
    reset = 1'b0;
    drive();
    ba.delete(); bb.delete();
  endtask

  task automatic enq_serial(logic [31:0] sn, logic [7:0] hits, int t);
    for (int i = 0; i < 8; i++)
      lq[i].push_back('{t, sn, 32'(i), hits[i], hits[i] ? ((64'(sn) << 8) | 64'(i)) : 64'd0});
  endtask

  task automatic wait_sn(logic [31:0] target, int budget);
    int n;
    n = 0;
    while (ifa.curr_sn !== target && n < budget) begin step(); n++; end
    chk("wait_curr_sn", ifa.curr_sn, target);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'd0, 8'hFF, 8'hFF, 1'b1, 1'b1, 64'h001};
    tbl[1] = '{32'd1, 8'hFF, 8'hFF, 1'b1, 1'b1, 64'h101};
    tbl[2] = '{32'd2, 8'hFF, 8'hFF, 1'b1, 1'b1, 64'h201};
    tbl[3] = '{32'd3, 8'hFF, 8'hFF, 1'b1, 1'b1, 64'h301};
    tbl[4] = '{32'd4, 8'h00, 8'h00, 1'b0, 1'b1, 64'h000};
    tbl[5] = '{32'd5, 8'h09, 8'h09, 1'b1, 1'b1, 64'h000};

    // Reset values, checked while reset is still asserted.
    reset = 1'b1;
    drive();
    step(); step();
    @(negedge clk);
    chk("rst_in_ready", ifa.in_ready, 8'h00);
    chk("rst_out_valid", {ifa.out_valid, ifb.out_valid}, 2'b00);
    chk("rst_out_data", ifa.out_data, 512'd0);
    chk("rst_keep_last", {ifa.out_keep, ifa.out_last}, 9'd0);
    chk("rst_curr_sn", ifa.curr_sn, 32'd0);
    chk("rst_err_sn", {ifa.err_sn, ifb.err_sn}, 2'b00);
    do_reset();

    // Ordered serials incl. an all-miss and a partial-hit serial.
    for (int r = 0; r < 6; r++) begin
      enq_serial(tbl[r].sn, tbl[r].hits, cyc);
      drive();
      wait_sn(tbl[r].sn + 32'd1, 20);
      step(); step();
      chk("tbl_count_a", ba.size(), tbl[r].emit_a);
      chk("tbl_count_b", bb.size(), tbl[r].emit_b);
      if (ba.size() == 1) begin
        chk("tbl_data_a", ba[0].data, exp_beat(tbl[r].sn, tbl[r].hits));
        chk("tbl_keep_a", {ba[0].keep, ba[0].last}, {tbl[r].exp_keep, 1'b0});
        chk("tbl_lane1_a", ba[0].data[127:64], tbl[r].exp_lane1);
      end
      if (bb.size() == 1) begin
        chk("tbl_data_b", bb[0].data, exp_beat(tbl[r].sn, tbl[r].hits));
        chk("tbl_keep_b", bb[0].keep, tbl[r].exp_keep);
      end
      ba.delete(); bb.delete();
    end

    // Skewed lane 5: other lanes must stall on serial 1 until serial 0 packs.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      lq[i].push_back('{cyc + (i == 5 ? 10 : 0), 32'd0, 32'(i), 1'b1, 64'(i)});
      lq[i].push_back('{cyc + (i == 5 ? 10 : 0), 32'd1, 32'(i), 1'b1, 64'h100 | 64'(i)});
    end
    drive();
    for (int k = 0; k < 6; k++) step();
    chk("skew_hold_ready", ifa.in_ready & 8'hDF, 8'h00);
    chk("skew_hold_sn", ifa.curr_sn, 32'd0);
    chk("skew_no_beat", ba.size(), 0);
    wait_sn(32'd2, 30);
    step(); step();
    chk("skew_beats", ba.size(), 2);
    if (ba.size() == 2) begin
      // Accepted in cycle k, slot full during k+1, beat visible in k+2.
      chk("skew_latency", ba[0].cyc - fire5_cyc, 2);
      chk("skew_beat0", ba[0].data, exp_beat(32'd0, 8'hFF));
      chk("skew_beat1", ba[1].data, exp_beat(32'd1, 8'hFF));
    end

    // Output backpressure with three serials queued.
    do_reset();
    enq_serial(32'd0, 8'hFF, cyc);
    enq_serial(32'd1, 8'hFF, cyc);
    enq_serial(32'd2, 8'hFF, cyc);
    stall_lo = cyc + 2; stall_hi = cyc + 7;
    drive();
    for (int k = 0; k < 4; k++) step();
    snap = ifa.out_data;
    chk("bp_valid", ifa.out_valid, 1'b1);
    chk("bp_ready_held", ifa.in_ready, 8'h00);
    step(); step();
    chk("bp_data_stable", ifa.out_data, snap);
    chk("bp_data_beat0", ifa.out_data, exp_beat(32'd0, 8'hFF));
    chk("bp_curr_sn", ifa.curr_sn, 32'd1);
    chk("bp_no_beat", ba.size(), 0);
    wait_sn(32'd3, 30);
    step(); step();
    chk("bp_beats", ba.size(), 3);
    if (ba.size() == 3)
      for (int k = 0; k < 3; k++) chk("bp_order", ba[k].data, exp_beat(32'(k), 8'hFF));

    // Stale serial on lane 2 after curr_sn reached 3.
    do_reset();
    for (int s = 0; s < 3; s++) enq_serial(32'(s), 8'hFF, cyc);
    drive();
    wait_sn(32'd3, 30);
    step(); step();
    ba.delete(); bb.delete();
    chk("err_clean", {ifa.err_sn, ifb.err_sn}, 2'b00);
    lq[2].push_back('{cyc, 32'd0, 32'd2, 1'b1, 64'h2});
    drive();
    step(); step(); step();
    chk("err_stale_consumed", lq[2].size(), 0);
    chk("err_stale_flag", {ifa.err_sn, ifb.err_sn}, 2'b11);
    chk("err_stale_sn", ifa.curr_sn, 32'd3);
    chk("err_stale_nobeat", ba.size() + bb.size(), 0);

    // Wrong lane index on lane 4; reset must also clear the sticky flag.
    do_reset();
    chk("err_rst_clear", {ifa.err_sn, ifb.err_sn}, 2'b00);
    lq[4].push_back('{cyc, 32'd0, 32'd6, 1'b1, 64'h4});
    drive();
    step(); step(); step();
    chk("err_lane_consumed", lq[4].size(), 0);
    chk("err_lane_flag", {ifa.err_sn, ifb.err_sn}, 2'b11);
    chk("err_lane_sn", ifa.curr_sn, 32'd0);
    chk("err_lane_nobeat", ba.size() + bb.size(), 0);

    // 17 serials wrap the 4-bit counter, then all lanes signal last.
    do_reset();
    for (int s = 0; s < 17; s++) enq_serial(32'(s), 8'hFF, cyc);
    drive();
    wait_sn(32'd17, 120);
    step(); step();
    chk("wrap_sn_b", ifb.curr_sn, 4'd1);
    chk("wrap_beats_a", ba.size(), 17);
    chk("wrap_beats_b", bb.size(), 17);
    if (bb.size() == 17) chk("wrap_beat16_b", bb[16].data, exp_beat(32'd16, 8'hFF));
    ba.delete(); bb.delete();
    last_mask = 8'hFF;
    drive();
    for (int k = 0; k < 4; k++) step();
    chk("term_beats", {ba.size(), bb.size()}, {32'd1, 32'd1});
    if (ba.size() == 1) begin
      chk("term_last", {ba[0].last, ba[0].keep}, {1'b1, 8'h00});
      chk("term_data", ba[0].data, 512'd0);
    end
    chk("done_valid", {ifa.out_valid, ifb.out_valid}, 2'b00);
    chk("done_ready", {ifa.in_ready, ifb.in_ready}, 16'h0000);
    lq[0].push_back('{cyc, 32'd17, 32'd0, 1'b1, 64'h1100});
    drive();
    step(); step();
    chk("done_no_accept", lq[0].size(), 1);
    chk("done_sn_frozen", ifa.curr_sn, 32'd17);
    chk("done_no_beat", ba.size(), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
